// File: rtl/serial_pattern_pkg.sv
// Shared types and default widths for the serial pattern transmitter.
package serial_pattern_pkg;

  localparam int unsigned DEF_MAX_LEN = 16;
  localparam int unsigned DEF_LEN_W   = 5;
  localparam int unsigned DEF_REP_W   = 4;
  localparam int unsigned DEF_GAP_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sp_down_counter.sv
// Loadable down counter that saturates at zero and flags when it has reached it.
module sp_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero_c
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial bit-stream transmitter: shifts a captured pattern out MSB-first, repeats it with
// optional idle gaps, then pulses done. All outputs are registered from next-state values.
module serial_pattern_gen
  import serial_pattern_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned REP_W   = DEF_REP_W,
  parameter int unsigned GAP_W   = DEF_GAP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   rep,
  input  logic [GAP_W-1:0]   gap,
  input  logic               abort,
  output logic               out,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  state_t state_q, state_d;

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [GAP_W-1:0]   gap_q;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               cap_en;

  logic               out_d, valid_d, busy_d, done_d;

  logic               idx_load, idx_en, idx_zero_c;
  logic [LEN_W-1:0]   idx_val, idx_q;
  logic               gap_load, gap_en, gap_zero_c;
  logic [GAP_W-1:0]   gap_val, gcnt_q;
  logic               unused_gcnt;

  logic               len_ok_c;

  // Bit select written as a compare loop so the index width need not match the pattern.
  function automatic logic bit_at(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] i);
    logic b;
    b = 1'b0;
    for (int unsigned k = 0; k < MAX_LEN; k++) begin
      if (LEN_W'(k) == i) b = p[k];
    end
    return b;
  endfunction

  sp_down_counter #(.W(LEN_W)) u_idx (
    .clk      (clk),
    .reset    (reset),
    .load     (idx_load),
    .load_val (idx_val),
    .en       (idx_en),
    .count    (idx_q),
    .zero_c   (idx_zero_c)
  );

  sp_down_counter #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (gap_val),
    .en       (gap_en),
    .count    (gcnt_q),
    .zero_c   (gap_zero_c)
  );

  // Only the zero flag of the gap counter steers the FSM.
  assign unused_gcnt = ^gcnt_q;

  assign len_ok_c = (len != '0) && (len <= LEN_W'(MAX_LEN));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      out     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      out     <= out_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
      rep_q   <= rep_d;
    end
  end

  // Transfer parameters are frozen for the whole transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q <= '0;
      len_q <= '0;
      gap_q <= '0;
    end else if (cap_en) begin
      pat_q <= pattern;
      len_q <= len;
      gap_q <= gap;
    end
  end

  always_comb begin
    state_d  = state_q;
    rep_d    = rep_q;
    cap_en   = 1'b0;
    out_d    = 1'b0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    idx_load = 1'b0;
    idx_val  = len_q - LEN_W'(1);
    idx_en   = 1'b0;
    gap_load = 1'b0;
    gap_val  = gap_q - GAP_W'(1);
    gap_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && len_ok_c) begin
          cap_en   = 1'b1;
          rep_d    = rep;
          idx_load = 1'b1;
          idx_val  = len - LEN_W'(1);
          out_d    = bit_at(pattern, len - LEN_W'(1));
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!idx_zero_c) begin
          idx_en  = 1'b1;
          out_d   = bit_at(pat_q, idx_q - LEN_W'(1));
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (rep_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = DONE;
        end else if (gap_q != '0) begin
          rep_d    = rep_q - REP_W'(1);
          gap_load = 1'b1;
          busy_d   = 1'b1;
          state_d  = GAP;
        end else begin
          // Back-to-back repetition: restart at the MSB with no bubble.
          rep_d    = rep_q - REP_W'(1);
          idx_load = 1'b1;
          out_d    = bit_at(pat_q, len_q - LEN_W'(1));
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end

      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gap_zero_c) begin
          idx_load = 1'b1;
          out_d    = bit_at(pat_q, len_q - LEN_W'(1));
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end else begin
          gap_en = 1'b1;
          busy_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen: each step advances one clock and checks
// {out,valid,busy,done} against hand-computed values.
module tb_serial_pattern_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic [3:0]  rep;
  logic [3:0]  gap;
  logic        abort;
  logic        out, valid, busy, done;

  int checks;
  int failures;

  logic [7:0]  pa;
  logic [13:0] s2_out;
  logic [13:0] s2_val;

  serial_pattern_gen dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .rep     (rep),
    .gap     (gap),
    .abort   (abort),
    .out     (out),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock, then check; start is a single-cycle pulse.
  task automatic step(input string tag, input logic eo, input logic ev, input logic eb,
                      input logic ed);
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    assert ({out, valid, busy, done} === {eo, ev, eb, ed})
    else begin
      failures++;
      $error("FAIL %s observed out/valid/busy/done=%b%b%b%b expected=%b%b%b%b",
             tag, out, valid, busy, done, eo, ev, eb, ed);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    start    = 1'b0;
    pattern  = '0;
    len      = '0;
    rep      = '0;
    gap      = '0;
    abort    = 1'b0;

    step("reset0", 0, 0, 0, 0);
    step("reset1", 0, 0, 0, 0);
    reset = 1'b1;
    step("idle", 0, 0, 0, 0);

    // Scenario 1: 4'b1011, single transmission.
    pattern = 16'h000B; len = 5'd4; rep = 4'd0; gap = 4'd0; start = 1'b1;
    step("s1_b3", 1, 1, 1, 0);
    step("s1_b2", 0, 1, 1, 0);
    step("s1_b1", 1, 1, 1, 0);
    step("s1_b0", 1, 1, 1, 0);
    step("s1_done", 0, 0, 1, 1);
    step("s1_idle", 0, 0, 0, 0);

    // Scenario 2: 1101 x3 with one-cycle gaps.
    pattern = 16'h000D; len = 5'd4; rep = 4'd2; gap = 4'd1; start = 1'b1;
    s2_out = 14'b1101_0_1101_0_1101;
    s2_val = 14'b1111_0_1111_0_1111;
    for (int i = 13; i >= 0; i--) begin
      step("s2_stream", s2_out[i], s2_val[i], 1, 0);
    end
    step("s2_done", 0, 0, 1, 1);
    step("s2_idle", 0, 0, 0, 0);

    // Scenario 3: illegal lengths are ignored.
    pattern = 16'h000B; rep = 4'd0; gap = 4'd0;
    len = 5'd0; start = 1'b1;
    step("s3_len0", 0, 0, 0, 0);
    step("s3_len0_b", 0, 0, 0, 0);
    len = 5'd17; start = 1'b1;
    step("s3_len17", 0, 0, 0, 0);
    step("s3_len17_b", 0, 0, 0, 0);

    // Scenario 3b: restart and input changes while busy have no effect.
    len = 5'd4; start = 1'b1;
    step("s3_b3", 1, 1, 1, 0);
    pattern = 16'hFFF4; len = 5'd2; rep = 4'd5; gap = 4'd3; start = 1'b1;
    step("s3_b2", 0, 1, 1, 0);
    step("s3_b1", 1, 1, 1, 0);
    step("s3_b0", 1, 1, 1, 0);
    step("s3_done", 0, 0, 1, 1);
    step("s3_idle", 0, 0, 0, 0);

    // Scenario 4: abort on the third bit of 8'hA5, then a clean restart.
    pa = 8'hA5;
    pattern = 16'h00A5; len = 5'd8; rep = 4'd3; gap = 4'd0; start = 1'b1;
    step("s4_b7", 1, 1, 1, 0);
    step("s4_b6", 0, 1, 1, 0);
    step("s4_b5", 1, 1, 1, 0);
    abort = 1'b1;
    step("s4_abort", 0, 0, 0, 0);
    abort = 1'b0;
    step("s4_idle", 0, 0, 0, 0);
    // start and abort together in IDLE: start wins.
    start = 1'b1; abort = 1'b1;
    step("s4_rs_b7", pa[7], 1, 1, 0);
    abort = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      step("s4_rs_rep0", pa[i], 1, 1, 0);
    end
    for (int r = 1; r <= 3; r++) begin
      for (int i = 7; i >= 0; i--) begin
        step("s4_rs_repn", pa[i], 1, 1, 0);
      end
    end
    step("s4_done", 0, 0, 1, 1);
    step("s4_idle", 0, 0, 0, 0);

    // Scenario 5: reset in the middle of a gap.
    pattern = 16'h000D; len = 5'd4; rep = 4'd1; gap = 4'd3; start = 1'b1;
    step("s5_b3", 1, 1, 1, 0);
    step("s5_b2", 1, 1, 1, 0);
    step("s5_b1", 0, 1, 1, 0);
    step("s5_b0", 1, 1, 1, 0);
    step("s5_gap", 0, 0, 1, 0);
    reset = 1'b0;
    step("s5_reset", 0, 0, 0, 0);
    reset = 1'b1;
    step("s5_post", 0, 0, 0, 0);
    pattern = 16'h000B; len = 5'd4; rep = 4'd0; gap = 4'd0; start = 1'b1;
    step("s5_b3n", 1, 1, 1, 0);
    step("s5_b2n", 0, 1, 1, 0);
    step("s5_b1n", 1, 1, 1, 0);
    step("s5_b0n", 1, 1, 1, 0);
    step("s5_done", 0, 0, 1, 1);
    step("s5_idle", 0, 0, 0, 0);

    // Scenario 6: one-bit pattern, 16 back-to-back repetitions.
    pattern = 16'h0001; len = 5'd1; rep = 4'd15; gap = 4'd0; start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step("s6_stream", 1, 1, 1, 0);
    end
    step("s6_done", 0, 0, 1, 1);
    step("s6_idle", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
